// File: rtl/branch_predictor.sv
// Branch predictor: direct-mapped BHT/BTB with 2-bit saturating counters,
// a two-stage prediction shadow pipe (fetch->decode->execute) and a
// running mispredict counter.
module branch_predictor #(
  parameter int ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_f,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        stall,
  input  logic        flush,
  output logic        ex_pred_taken,
  input  logic        upd_en,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  output logic        mispredict,
  output logic [15:0] mispredict_cnt
);

  localparam int IDX   = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX;

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [TAG_W-1:0]   tag_d    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  logic [31:0]        target_d [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];
  logic [1:0]         ctr_d    [ENTRIES];

  logic        pd_q, pd_d;
  logic        pe_q, pe_d;
  logic [15:0] cnt_q, cnt_d;

  logic [IDX-1:0]   f_idx, u_idx;
  logic [TAG_W-1:0] f_tag, u_tag;
  logic             u_hit;

  // Byte-offset bits of both PCs carry no information for word-aligned branches.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{pc_f[1:0], upd_pc[1:0]};

  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'd1;
  endfunction

  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'd1;
  endfunction

  assign f_idx = pc_f[IDX+1:2];
  assign f_tag = pc_f[31:IDX+2];
  assign u_idx = upd_pc[IDX+1:2];
  assign u_tag = upd_pc[31:IDX+2];
  assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

  // Fetch-stage lookup reads current (pre-update) table state.
  always_comb begin
    pred_taken  = valid_q[f_idx] && (tag_q[f_idx] == f_tag) && ctr_q[f_idx][1];
    pred_target = pred_taken ? target_q[f_idx] : 32'h0;
  end

  assign ex_pred_taken = pe_q;
  assign mispredict    = upd_en && (upd_taken != pe_q);
  assign mispredict_cnt = cnt_q;

  // Next table state from the resolved branch in execute.
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    if (upd_en) begin
      if (u_hit) begin
        ctr_d[u_idx] = upd_taken ? ctr_inc(ctr_q[u_idx]) : ctr_dec(ctr_q[u_idx]);
        if (upd_taken) begin
          target_d[u_idx] = upd_target;
        end
      end else if (upd_taken) begin
        valid_d[u_idx]  = 1'b1;
        tag_d[u_idx]    = u_tag;
        target_d[u_idx] = upd_target;
        ctr_d[u_idx]    = 2'b10;
      end
    end
  end

  // Shadow pipe next state: flush clears, stall holds, otherwise advance.
  always_comb begin
    pd_d = pd_q;
    pe_d = pe_q;
    if (flush) begin
      pd_d = 1'b0;
      pe_d = 1'b0;
    end else if (!stall) begin
      pd_d = pred_taken;
      pe_d = pd_q;
    end
  end

  // Mispredict counter next state, wraps naturally at 16 bits.
  always_comb begin
    cnt_d = cnt_q + {15'd0, mispredict};
  end

  // State registers; reset returns the table to weakly-not-taken, invalid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
      pd_q  <= 1'b0;
      pe_q  <= 1'b0;
      cnt_q <= 16'h0;
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      ctr_q    <= ctr_d;
      pd_q     <= pd_d;
      pe_q     <= pe_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor (ENTRIES=16: index pc[5:2], tag pc[31:6]).
module tb_branch_predictor;

  logic        clk;
  logic        rst;
  logic [31:0] pc_f;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        stall;
  logic        flush;
  logic        ex_pred_taken;
  logic        upd_en;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        mispredict;
  logic [15:0] mispredict_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  branch_predictor #(.ENTRIES(16)) dut (
    .clk(clk), .rst(rst), .pc_f(pc_f),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .stall(stall), .flush(flush), .ex_pred_taken(ex_pred_taken),
    .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .mispredict(mispredict),
    .mispredict_cnt(mispredict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: observed timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic en, input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
    upd_en = en; upd_pc = pc; upd_taken = tk; upd_target = tgt;
  endtask

  initial begin
    rst = 1'b1; pc_f = 32'h100; stall = 1'b0; flush = 1'b0;
    upd(1'b0, 32'h0, 1'b0, 32'h0);
    #2;
    // Reset state
    check("rst_pred_taken", {31'd0, pred_taken}, 32'd0);
    check("rst_pred_target", pred_target, 32'h0);
    check("rst_ex_pred", {31'd0, ex_pred_taken}, 32'd0);
    check("rst_cnt", {16'd0, mispredict_cnt}, 32'd0);
    check("rst_mispred_idle", {31'd0, mispredict}, 32'd0);
    upd(1'b1, 32'h100, 1'b1, 32'h180);
    #1;
    check("rst_mispred_upd_taken", {31'd0, mispredict}, 32'd1);
    tick();
    check("rst_no_update", {31'd0, pred_taken}, 32'd0);
    upd(1'b0, 32'h0, 1'b0, 32'h0);
    rst = 1'b0;
    tick();

    // First taken branch allocates; lookup same cycle still sees old state
    upd(1'b1, 32'h100, 1'b1, 32'h180);
    #1;
    check("alloc_mispred", {31'd0, mispredict}, 32'd1);
    check("alloc_rbw_pred", {31'd0, pred_taken}, 32'd0);
    tick();
    upd(1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    check("alloc_cnt", {16'd0, mispredict_cnt}, 32'd1);
    check("alloc_pred", {31'd0, pred_taken}, 32'd1);
    check("alloc_target", pred_target, 32'h180);

    // Counter saturation; flush keeps shadow pipe at 0 so every taken update mispredicts
    flush = 1'b1;
    upd(1'b1, 32'h100, 1'b1, 32'h180);
    tick(); tick();                       // ctr 10->11->11, cnt 3
    check("ctr_sat_hi_pred", {31'd0, pred_taken}, 32'd1);
    check("ctr_cnt3", {16'd0, mispredict_cnt}, 32'd3);
    upd(1'b1, 32'h100, 1'b0, 32'h0);
    #1;
    check("nt_no_mispred", {31'd0, mispredict}, 32'd0);
    tick();                               // 11->10
    check("nt1_pred", {31'd0, pred_taken}, 32'd1);
    check("nt1_target_kept", pred_target, 32'h180);
    tick();                               // 10->01
    check("nt2_pred", {31'd0, pred_taken}, 32'd0);
    check("nt2_target", pred_target, 32'h0);
    tick(); tick();                       // 01->00->00
    check("nt4_pred", {31'd0, pred_taken}, 32'd0);
    upd(1'b1, 32'h100, 1'b1, 32'h1C0);
    tick();                               // 00->01 (no wrap to 11)
    check("ctr_sat_lo_pred", {31'd0, pred_taken}, 32'd0);
    tick();                               // 01->10
    check("retaken_pred", {31'd0, pred_taken}, 32'd1);
    check("hit_target_upd", pred_target, 32'h1C0);
    check("ctr_cnt5", {16'd0, mispredict_cnt}, 32'd5);

    // upd_en=0 leaves table alone
    upd(1'b0, 32'h104, 1'b1, 32'h999);
    tick();
    pc_f = 32'h104;
    #1;
    check("no_upd_en_pred", {31'd0, pred_taken}, 32'd0);

    // Aliasing: 0x500 shares index 0 with 0x100
    pc_f = 32'h500;
    #1;
    check("alias_miss", {31'd0, pred_taken}, 32'd0);
    upd(1'b1, 32'h500, 1'b0, 32'h0);
    tick();
    pc_f = 32'h100;
    #1;
    check("miss_nt_no_change", {31'd0, pred_taken}, 32'd1);
    upd(1'b1, 32'h500, 1'b1, 32'h600);
    tick();
    upd(1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    check("alias_old_evicted", {31'd0, pred_taken}, 32'd0);
    pc_f = 32'h500;
    #1;
    check("alias_new_pred", {31'd0, pred_taken}, 32'd1);
    check("alias_new_target", pred_target, 32'h600);
    check("alias_cnt6", {16'd0, mispredict_cnt}, 32'd6);

    // Shadow pipe: plain advance
    flush = 1'b0;
    tick();                               // pd=1
    pc_f = 32'h104;
    check("pipe_n1", {31'd0, ex_pred_taken}, 32'd0);
    tick();                               // pe=1
    check("pipe_n2", {31'd0, ex_pred_taken}, 32'd1);
    upd(1'b1, 32'h500, 1'b1, 32'h600);
    #1;
    check("pipe_correct_pred", {31'd0, mispredict}, 32'd0);
    upd(1'b1, 32'h500, 1'b0, 32'h0);
    #1;
    check("pipe_wrong_pred", {31'd0, mispredict}, 32'd1);
    upd(1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    check("pipe_n3", {31'd0, ex_pred_taken}, 32'd0);

    // Shadow pipe: stall delays by one
    pc_f = 32'h500;
    tick();                               // pd=1
    pc_f = 32'h104; stall = 1'b1;
    tick();                               // hold
    check("stall_hold", {31'd0, ex_pred_taken}, 32'd0);
    stall = 1'b0;
    tick();
    check("stall_n3", {31'd0, ex_pred_taken}, 32'd1);
    tick();
    check("stall_drain", {31'd0, ex_pred_taken}, 32'd0);

    // Shadow pipe: flush clears pd before it reaches execute
    pc_f = 32'h500;
    tick();                               // pd=1
    pc_f = 32'h104; flush = 1'b1;
    tick();
    check("flush_n2", {31'd0, ex_pred_taken}, 32'd0);
    flush = 1'b0;
    tick();
    check("flush_n3", {31'd0, ex_pred_taken}, 32'd0);

    // Shadow pipe: flush wins over stall
    pc_f = 32'h500;
    tick(); tick();                       // pd=1, pe=1
    check("fs_pre", {31'd0, ex_pred_taken}, 32'd1);
    flush = 1'b1; stall = 1'b1;
    tick();
    check("fs_cleared", {31'd0, ex_pred_taken}, 32'd0);
    flush = 1'b0; stall = 1'b0; pc_f = 32'h104;
    tick();
    check("fs_pd_cleared", {31'd0, ex_pred_taken}, 32'd0);

    // Counter wrap: 6 + 65529 = 0xFFFF, then one more wraps
    flush = 1'b1;
    upd(1'b1, 32'h208, 1'b1, 32'h240);
    for (int i = 0; i < 65529; i++) begin
      tick();
    end
    check("cnt_ffff", {16'd0, mispredict_cnt}, 32'h0000FFFF);
    tick();
    check("cnt_wrap", {16'd0, mispredict_cnt}, 32'h0);
    tick();
    check("cnt_after_wrap", {16'd0, mispredict_cnt}, 32'h1);

    // Asynchronous reset mid-run
    upd(1'b0, 32'h0, 1'b0, 32'h0);
    flush = 1'b0; pc_f = 32'h208;
    tick(); tick();
    check("pre_rst_pred", {31'd0, pred_taken}, 32'd1);
    check("pre_rst_ex", {31'd0, ex_pred_taken}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_pred", {31'd0, pred_taken}, 32'd0);
    check("arst_target", pred_target, 32'h0);
    check("arst_ex", {31'd0, ex_pred_taken}, 32'd0);
    check("arst_cnt", {16'd0, mispredict_cnt}, 32'h0);
    check("arst_mispred", {31'd0, mispredict}, 32'd0);

    // Update during reset is discarded
    upd(1'b1, 32'h10C, 1'b1, 32'h300);
    tick();
    upd(1'b0, 32'h0, 1'b0, 32'h0);
    rst = 1'b0;
    pc_f = 32'h10C;
    #1;
    check("rst_upd_discard", {31'd0, pred_taken}, 32'd0);
    pc_f = 32'h500;
    #1;
    check("rst_table_clear", {31'd0, pred_taken}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter ENTRIES, default 16, number of BHT/BTB entries (power of two, 4..64); IDX = log2(ENTRIES).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 pc_f  input  32  fetch-stage PC to predict.
REQ-005 pred_taken  output  1  fetch-stage prediction (combinational from pc_f and table state).
REQ-006 pred_target  output  32  predicted target for pc_f; 0 when pred_taken=0.
REQ-007 stall  input  1  pipeline stall; holds prediction shadow registers.
REQ-008 flush  input  1  pipeline flush; clears prediction shadow registers.
REQ-009 ex_pred_taken  output  1  prediction carried to execute stage, fed to the control unit as br_prediction.
REQ-010 upd_en  input  1  resolved conditional branch present in execute this cycle.
REQ-011 upd_pc  input  32  PC of resolved branch.
REQ-012 upd_taken  input  1  actual outcome (br_actual).
REQ-013 upd_target  input  32  computed branch target.
REQ-014 mispredict  output  1  upd_en and (upd_taken != ex_pred_taken), combinational.
REQ-015 mispredict_cnt  output  16  running mispredict count.

Function
REQ-016 Index = pc[IDX+1:2]; tag = pc[31:IDX+2]; pc[1:0] ignored.
REQ-017 Each entry holds valid (1), tag, target (32), 2-bit saturating counter ctr.
REQ-018 pred_taken = valid[i] and tag match and ctr[i][1]; otherwise 0.
REQ-019 pred_target = target[i] when pred_taken=1, else 32'h0.
REQ-020 Shadow pipe: pd (fetch->decode), pe (decode->execute); ex_pred_taken = pe.
REQ-021 Each cycle, flush=1: pd<=0, pe<=0; else stall=1: hold pd, pe; else pd<=pred_taken, pe<=pd.
REQ-022 flush has priority over stall.
REQ-023 Update on upd_en=1 with entry j = index(upd_pc), hit = valid[j] and tag match.
REQ-024 Hit: ctr increments on taken, decrements on not-taken, saturating at 2'b11 / 2'b00; target<=upd_target on taken.
REQ-025 Miss and upd_taken=1: allocate (valid<=1, tag, target<=upd_target, ctr<=2'b10), overwriting any prior entry.
REQ-026 Miss and upd_taken=0: no table change.
REQ-027 upd_en=0: no table change; stall/flush do not gate table updates.
REQ-028 Same-cycle lookup and update of same entry: lookup uses pre-update state (read-before-write); new state visible next cycle.
REQ-029 mispredict_cnt increments by 1 on each cycle mispredict=1; wraps 16'hFFFF -> 16'h0000.

Reset
REQ-030 rst=1 asynchronously clears all valid bits, sets every ctr to 2'b01, clears targets, tags, pd, pe, mispredict_cnt.
REQ-031 During reset pred_taken=0, pred_target=0, ex_pred_taken=0, mispredict=0 unless upd_en=1 and upd_taken=1.
REQ-032 Reset asserted mid-update: update discarded; table returns to reset state.

Verification
REQ-033 Reset, pc_f=0x100 -> pred_taken=0, pred_target=0, ex_pred_taken=0, mispredict_cnt=0.
REQ-034 upd_en, upd_pc=0x100, taken, target=0x180 -> mispredict=1, cnt=1; next cycle pc_f=0x100 -> pred_taken=1, pred_target=0x180.
REQ-035 Same entry: 3 taken updates -> ctr=11; 1 not-taken -> still predicts taken; 2nd not-taken -> pred_taken=0; 3rd -> ctr=00 holds.
REQ-036 Aliasing: 0x100 allocated; pc_f=0x500 (same index, different tag) -> pred_taken=0; taken update at 0x500 target 0x600 replaces entry, 0x100 now misses.
REQ-037 Shadow pipe: pred_taken=1 cycle N -> ex_pred_taken=1 at N+2; stall at N+1 -> at N+3; flush at N+1 -> ex_pred_taken=0, flush+stall together -> cleared.
REQ-038 Preload mispredict_cnt to 16'hFFFF via 65535 mispredicts, one more -> 16'h0000; rst mid-run -> all outputs to REQ-030/031 values immediately, no clock edge needed.
